// File: rtl/hash_ram_writer_if.sv
// Stream-in / BRAM-write bundle for hash_ram_writer.
// slave = the writer (consumes the stream, drives the BRAM port); master = stream source / BRAM side.
interface hash_ram_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wmask;

    modport slave (
        input  s_valid, s_data,
        output s_ready, wen, waddr, wdata, wmask
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, wen, waddr, wdata, wmask
    );
endinterface

// File: rtl/hash_ram_writer.sv
// Fills two ping-pong HASH BRAM row buffers from the SHAKE squeeze stream and hands rows to the consumer.
// Optional macro HASH_WR_BYTESWAP_EN: byte-reverse each stream word before it is written.
module hash_ram_writer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] buf_stride,
    input  logic [CNT_W-1:0]  row_words,
    input  logic [10:0]       num_rows,
    hash_ram_writer_if.slave  bus,
    output logic              row_valid,
    output logic              row_buf,
    input  logic              row_release,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_BUF,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [1:0]        full_q;
    logic              fill_sel_q;
    logic              rd_sel_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [10:0]       row_cnt_q;
    logic [ADDR_W-1:0] base0_q;
    logic [ADDR_W-1:0] base1_q;
    logic [CNT_W-1:0]  row_words_q;
    logic [10:0]       num_rows_q;
    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pend_q;
    logic              pend_buf_q;
    logic              busy_q;
    logic              done_q;

    logic              s_ready_c;
    logic              accept;
    logic              rel;
    logic              row_end;
    logic              last_row;
    logic [1:0]        clr_vec;
    logic [1:0]        set_vec;
    logic [1:0]        full_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wr_word;

    assign s_ready_c = (state_q == S_FILL) && !full_q[fill_sel_q];
    assign accept    = bus.s_valid && s_ready_c;
    assign rel       = row_release && full_q[rd_sel_q];
    assign row_end   = accept && (word_cnt_q == row_words_q - CNT_W'(1));
    assign last_row  = (row_cnt_q == num_rows_q - 11'd1);
    assign waddr_d   = (fill_sel_q ? base1_q : base0_q) + ADDR_W'(word_cnt_q) * STEP;

    // A finished row is marked full one cycle after its last write, so the data is
    // committed in BRAM before the consumer can see row_valid.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            assign clr_vec[gi] = rel && (rd_sel_q == 1'(gi));
            assign set_vec[gi] = pend_q && (pend_buf_q == 1'(gi));
        end
    endgenerate

    assign full_d = (full_q & ~clr_vec) | set_vec;

`ifdef HASH_WR_BYTESWAP_EN
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_swap
            assign wr_word[DATA_W-1-8*gi -: 8] = bus.s_data[8*gi +: 8];
        end
    endgenerate
`else
    assign wr_word = bus.s_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            full_q      <= 2'b00;
            fill_sel_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            word_cnt_q  <= '0;
            row_cnt_q   <= '0;
            base0_q     <= '0;
            base1_q     <= '0;
            row_words_q <= '0;
            num_rows_q  <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pend_q      <= 1'b0;
            pend_buf_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wen_q  <= accept;
            pend_q <= row_end;
            done_q <= 1'b0;
            full_q <= full_d;
            if (accept) begin
                waddr_q <= waddr_d;
                wdata_q <= wr_word;
            end
            if (row_end) begin
                pend_buf_q <= fill_sel_q;
                word_cnt_q <= '0;
                fill_sel_q <= ~fill_sel_q;
                row_cnt_q  <= row_cnt_q + 11'd1;
            end else if (accept) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
            if (rel) begin
                rd_sel_q <= ~rd_sel_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base0_q     <= base_addr;
                        base1_q     <= base_addr + buf_stride;
                        row_words_q <= row_words;
                        num_rows_q  <= num_rows;
                        word_cnt_q  <= '0;
                        row_cnt_q   <= '0;
                        fill_sel_q  <= 1'b0;
                        rd_sel_q    <= 1'b0;
                        full_q      <= 2'b00;
                        if (row_words == '0 || num_rows == 11'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FILL;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (row_end) begin
                        if (last_row) begin
                            state_q <= S_DRAIN;
                        end else if (full_d[~fill_sel_q]) begin
                            state_q <= S_WAIT_BUF;
                        end
                    end
                end
                S_WAIT_BUF: begin
                    if (!full_q[fill_sel_q]) begin
                        state_q <= S_FILL;
                    end
                end
                S_DRAIN: begin
                    // Every row is written; the job ends on the release that empties both buffers.
                    if (rel && full_d == 2'b00) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.wen     = wen_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;
    assign bus.wmask   = 8'hFF;
    assign row_valid   = full_q[rd_sel_q];
    assign row_buf     = rd_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule
